uart_bus_bridge: RTL and testbench

Memory-mapped UART controller between the CPU data bus and the byte-level serial transmitter/receiver pair. It buffers outgoing bytes in a TX FIFO, which a drain FSM feeds one byte at a time into the transmitter's start/busy handshake. It captures the receiver's one-cycle data-ready pulses into an RX FIFO. It exposes data, status and control registers plus a level interrupt to the CPU.

---
 rtl/uart_bus_bridge.sv | 194 +++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// Memory-mapped UART bridge: TX/RX byte FIFOs, TX drain FSM, DATA/STATUS/CTRL registers, level irq.
// Optional CTRL.LOOP loopback is built only when UART_BRIDGE_LOOPBACK_EN is defined.
//
// state     | meaning
// IDLE      | ready to hand the next TX byte to the transmitter
// WAIT_BUSY | start issued, waiting for the transmitter to raise busy
// WAIT_DONE | transmitter busy, waiting for it to finish the byte
module uart_bus_bridge #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_en,
    input  logic       bus_we,
    input  logic [3:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic       irq,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_ready,
    input  logic [7:0] rx_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
`ifdef UART_BRIDGE_LOOPBACK_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_next;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_count;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_count;

    logic [2:0] ctrl;
    logic       rx_ovr, tx_drop;
    logic       rx_empty, rx_full, tx_empty, tx_full, tx_idle;
    logic       rd_data, wr_data, rd_status, wr_ctrl;
    logic       rx_pop, rx_push, rx_push_req, rx_ovf;
    logic [7:0] rx_push_byte, tx_head;
    logic       tx_pop, tx_push, tx_drop_evt;
    logic       start_next, fsm_pop;
    logic [7:0] rd_value, status;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CNT_FULL);
    assign tx_idle  = tx_empty && (state == IDLE);
    assign tx_head  = tx_mem[tx_rptr];

    assign rd_data   = bus_en && !bus_we && (bus_addr == ADDR_DATA);
    assign wr_data   = bus_en &&  bus_we && (bus_addr == ADDR_DATA);
    assign rd_status = bus_en && !bus_we && (bus_addr == ADDR_STATUS);
    assign wr_ctrl   = bus_en &&  bus_we && (bus_addr == ADDR_CTRL);

`ifdef UART_BRIDGE_LOOPBACK_EN
    logic loop, loop_push;
    assign loop         = ctrl[2];
    assign rx_push_req  = loop ? loop_push : rx_ready;
    assign rx_push_byte = loop ? tx_head : rx_data;
`else
    assign rx_push_req  = rx_ready;
    assign rx_push_byte = rx_data;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign rx_pop      = rd_data && !rx_empty;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovf      = rx_push_req && rx_full && !rx_pop;
    assign tx_pop      = fsm_pop;
    assign tx_push     = wr_data && (!tx_full || tx_pop);
    assign tx_drop_evt = wr_data && tx_full && !tx_pop;

    assign status = {3'b000, tx_drop, tx_idle, rx_ovr, !tx_full, !rx_empty};

    always_comb begin
        rd_value = 8'h00;
        case (bus_addr)
            ADDR_DATA:   rd_value = rx_empty ? 8'h00 : rx_mem[rx_rptr];
            ADDR_STATUS: rd_value = status;
            ADDR_CTRL:   rd_value = {5'b00000, ctrl};
            default:     rd_value = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state;
        start_next = 1'b0;
        fsm_pop    = 1'b0;
`ifdef UART_BRIDGE_LOOPBACK_EN
        loop_push  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    fsm_pop = 1'b1;
`ifdef UART_BRIDGE_LOOPBACK_EN
                    if (loop) begin
                        loop_push = 1'b1;
                    end else begin
                        start_next = 1'b1;
                        state_next = WAIT_BUSY;
                    end
`else
                    start_next = 1'b1;
                    state_next = WAIT_BUSY;
`endif
                end
            end
            WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_next;
            tx_start <= start_next;
            if (start_next) tx_data <= tx_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_push_byte;
        if (tx_push) tx_mem[tx_wptr] <= bus_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // A new sticky event in the same cycle as a STATUS read wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ack   <= 1'b0;
            bus_rdata <= 8'h00;
            ctrl      <= 3'b000;
            rx_ovr    <= 1'b0;
            tx_drop   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            bus_ack   <= bus_en;
            bus_rdata <= (bus_en && !bus_we) ? rd_value : 8'h00;
            if (wr_ctrl) ctrl <= bus_wdata[2:0] & CTRL_MASK;
            if (rx_ovf)         rx_ovr <= 1'b1;
            else if (rd_status) rx_ovr <= 1'b0;
            if (tx_drop_evt)    tx_drop <= 1'b1;
            else if (rd_status) tx_drop <= 1'b0;
            irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_idle);
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed self-checking bench for uart_bus_bridge with a simple transmitter busy model.
module tb_uart_bus_bridge;
    logic       clk = 1'b0;
    logic       rst, bus_en, bus_we, tx_busy, rx_ready, irq, tx_start, bus_ack;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata, tx_data, rx_data;

    int tests = 0, fails = 0;
    int cyc = 0, w_cyc = 0, busy_cnt = 0;
    logic busy_force = 1'b0;
    logic [7:0] starts[$];
    int start_cyc[$];
    bit double_start = 1'b0;
    bit prev_start = 1'b0;

    uart_bus_bridge #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .irq(irq),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_ready(rx_ready), .rx_data(rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: raises busy the cycle after a start and holds it for 20 cycles.
    assign tx_busy = busy_force | (busy_cnt != 0);
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (tx_start)      busy_cnt <= 20;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            starts.push_back(tx_data);
            start_cyc.push_back(cyc);
            if (prev_start) double_start = 1'b1;
        end
        prev_start = (tx_start === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_op(input logic we, input logic [3:0] addr, input logic [7:0] wd);
        bus_en = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        @(posedge clk);
        #1;
        bus_en = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 8'h00;
        check("bus_ack", bus_ack, 1);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] d);
        bus_op(1'b1, addr, d);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        bus_op(1'b0, addr, 8'h00);
        check(tag, bus_rdata, exp);
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_ready = 1'b1; rx_data = d;
        tick(1);
        rx_ready = 1'b0; rx_data = 8'h00;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (starts.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("start_count", starts.size(), n);
    endtask

    initial begin
        int n;
        rst = 1'b1; bus_en = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 8'h00;
        rx_ready = 1'b0; rx_data = 8'h00;
        tick(3);
        check("rst_bus_ack", bus_ack, 0);
        check("rst_bus_rdata", bus_rdata, 0);
        check("rst_irq", irq, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        rst = 1'b0;
        rd_chk("status_after_reset", 4'h4, 8'h0A);
        check("irq_after_reset", irq, 0);
        tick(1);
        check("ack_drops", bus_ack, 0);
        check("rdata_zero_no_ack", bus_rdata, 0);
        check("no_start_idle", starts.size(), 0);

        wr(4'h0, 8'h55);
        w_cyc = cyc;
        wr(4'h0, 8'hA3);
        wait_starts(2, 100);
        check("start0_data", starts[0], 8'h55);
        check("start0_latency", start_cyc[0], w_cyc + 1);
        check("start1_data", starts[1], 8'hA3);
        check("start_gap", start_cyc[1] - start_cyc[0], 23);
        check("no_double_start", double_start, 0);
        tick(30);
        check("tx_data_hold", tx_data, 8'hA3);
        check("tx_start_count_stable", starts.size(), 2);

        for (int i = 0; i < 17; i++) rx_push(8'(i));
        rd_chk("status_rx_ovr", 4'h4, 8'h0F);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("rx_read_%0d", i), 4'h0, 8'(i));
        rd_chk("rx_read_empty", 4'h0, 8'h00);
        rd_chk("status_ovr_cleared", 4'h4, 8'h0A);

        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) wr(4'h0, 8'(8'h80 + i));
        wr(4'h0, 8'hFF);
        rd_chk("status_tx_full_drop", 4'h4, 8'h10);
        rd_chk("status_drop_cleared", 4'h4, 8'h00);
        busy_force = 1'b0;
        wait_starts(18, 600);
        for (int i = 0; i < 16; i++) check($sformatf("drain_%0d", i), starts[2 + i], 8'h80 + i);
        tick(40);
        check("dropped_never_sent", starts.size(), 18);
        check("no_double_start_drain", double_start, 0);
        rd_chk("status_tx_drained", 4'h4, 8'h0A);

        for (int i = 0; i < 16; i++) rx_push(8'(8'h20 + i));
        rx_ready = 1'b1; rx_data = 8'h77;
        rd_chk("simul_pop_head", 4'h0, 8'h20);
        rx_ready = 1'b0; rx_data = 8'h00;
        rd_chk("simul_no_ovr", 4'h4, 8'h0B);
        for (int i = 1; i < 16; i++) rd_chk($sformatf("simul_read_%0d", i), 4'h0, 8'(8'h20 + i));
        rd_chk("simul_tail", 4'h0, 8'h77);
        rd_chk("simul_empty", 4'h0, 8'h00);

        wr(4'h8, 8'h01);
        rd_chk("ctrl_rxie", 4'h8, 8'h01);
        check("irq_rx_empty", irq, 0);
        rx_push(8'h5A);
        check("irq_one_cycle", irq, 0);
        tick(1);
        check("irq_two_cycles", irq, 1);
        wr(4'h8, 8'hFF);
`ifdef UART_BRIDGE_LOOPBACK_EN
        rd_chk("ctrl_all_bits", 4'h8, 8'h07);
`else
        rd_chk("ctrl_all_bits", 4'h8, 8'h03);
`endif
        wr(4'h8, 8'h02);
        tick(1);
        check("irq_txie_idle", irq, 1);
        wr(4'h8, 8'h00);
        check("irq_before_update", irq, 1);
        tick(1);
        check("irq_cleared", irq, 0);
        rd_chk("irq_byte_read", 4'h0, 8'h5A);
        wr(4'hC, 8'hFF);
        rd_chk("reserved_read", 4'hC, 8'h00);
        wr(4'h4, 8'hFF);
        rd_chk("status_write_ignored", 4'h4, 8'h0A);

`ifdef UART_BRIDGE_LOOPBACK_EN
        wr(4'h8, 8'h04);
        n = starts.size();
        wr(4'h0, 8'h3C);
        tick(10);
        check("loop_no_start", starts.size(), n);
        rd_chk("loop_rx_byte", 4'h0, 8'h3C);
        wr(4'h8, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
